timings_to_steps: RTL

//  Consumer of one axis's timing parameter set {N, nn, t0, tna, delta}. Generates a trapezoidal

---
 rtl/stepper_pkg.sv | 37 +++
 rtl/step_pulse_timer.sv | 42 ++++
 rtl/timings_to_steps.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared types and 33-bit saturating period arithmetic for the step generator.
package stepper_pkg;
  localparam int PARAM_N     = 0;
  localparam int PARAM_NN    = 1;
  localparam int PARAM_T0    = 2;
  localparam int PARAM_TNA   = 3;
  localparam int PARAM_DELTA = 4;

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, ACCEL, CRUISE, DECEL, DONE} step_state_t;

  typedef logic [32:0] per_t;
  localparam per_t PER_MAX = '1;

  function automatic per_t sat_sub(input per_t a, input per_t b);
    return (b > a) ? '0 : a - b;
  endfunction

  function automatic per_t sat_add(input per_t a, input per_t b);
    logic [33:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[33] ? PER_MAX : s[32:0];
  endfunction

  function automatic per_t sat_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return (|p[63:33]) ? PER_MAX : p[32:0];
  endfunction

  function automatic per_t pmax(input per_t a, input per_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic per_t pmin(input per_t a, input per_t b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/step_pulse_timer.sv
// Times one step period: STEP high for STEP_PULSE clocks from the go edge,
// period_done_o on the last clock of the loaded period.
module step_pulse_timer #(
  parameter int STEP_PULSE = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        kill_i,
  input  logic        go_i,
  input  logic [32:0] period_i,
  output logic        step_o,
  output logic        period_done_o
);
  logic        active_q;
  logic        step_q;
  logic [32:0] cnt_q;
  logic [32:0] per_q;

  assign period_done_o = active_q && (cnt_q == per_q - 33'd1);
  assign step_o        = step_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || kill_i) begin
      active_q <= 1'b0;
      step_q   <= 1'b0;
      cnt_q    <= '0;
      per_q    <= '0;
    end else if (go_i) begin
      // back-to-back restart: new period starts the cycle after the old one ends
      active_q <= 1'b1;
      step_q   <= 1'b1;
      cnt_q    <= '0;
      per_q    <= period_i;
    end else if (period_done_o) begin
      active_q <= 1'b0;
      step_q   <= 1'b0;
    end else if (active_q) begin
      cnt_q  <= cnt_q + 33'd1;
      step_q <= (cnt_q + 33'd1) < 33'(STEP_PULSE);
    end
  end
endmodule

// File: rtl/timings_to_steps.sv
// Trapezoidal STEP/DIR generator for one axis: accel ramp, cruise, decel ramp.
module timings_to_steps
  import stepper_pkg::*;
#(
  parameter int STEP_PULSE = 10,
  parameter int DIR_SETUP  = 20,
  parameter int MIN_PERIOD = 20
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            dir_in_i,
  input  logic [4:0][31:0] params_i,
  output logic            step_o,
  output logic            dir_o,
  output logic            busy_o,
  output logic            finish_o
);
  step_state_t state_q, state_d;
  logic        dir_q, busy_q, finish_q;
  logic [31:0] t0_q, tna_q, delta_q, setup_cnt_q;
  logic [31:0] acc_rem_q, cru_rem_q, dec_rem_q;
  per_t        acc_p_q, dec_p_q, cruise_p_q;

  logic        in_move, launch, go, kill, take_acc, take_cru, take_dec;
  per_t        go_p, ld_cp;
  logic [31:0] ld_n, ld_ramp;
  logic        tmr_step, tmr_done;

  always_comb begin
    ld_n    = params_i[PARAM_N];
    ld_ramp = (params_i[PARAM_NN] < (ld_n >> 1)) ? params_i[PARAM_NN] : (ld_n >> 1);
    ld_cp   = pmax({1'b0, params_i[PARAM_TNA]},
                   sat_sub({1'b0, params_i[PARAM_T0]}, sat_mul(ld_ramp, params_i[PARAM_DELTA])));
  end

  assign in_move = state_q inside {LOAD, SETUP, ACCEL, CRUISE, DECEL};

  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    go       = 1'b0;
    go_p     = '0;
    kill     = 1'b0;
    take_acc = 1'b0;
    take_cru = 1'b0;
    take_dec = 1'b0;
    case (state_q)
      IDLE:                 if (start_i) state_d = LOAD;
      LOAD:                 state_d = (ld_n == 32'd0) ? DONE : SETUP;
      SETUP:                launch = (setup_cnt_q == 32'(DIR_SETUP - 1));
      ACCEL, CRUISE, DECEL: launch = tmr_done;
      DONE:                 if (!start_i) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
    // abort: never start a new pulse, let a high pulse run to full width
    if (in_move && !start_i) begin
      launch  = 1'b0;
      state_d = state_q;
      if (!tmr_step) begin
        state_d = IDLE;
        kill    = 1'b1;
      end
    end
    // phases are drained in order; empty ones fall through with no gap
    if (launch) begin
      go = 1'b1;
      if (acc_rem_q != 32'd0) begin
        state_d  = ACCEL;
        take_acc = 1'b1;
        go_p     = pmax({1'b0, tna_q}, acc_p_q);
      end else if (cru_rem_q != 32'd0) begin
        state_d  = CRUISE;
        take_cru = 1'b1;
        go_p     = cruise_p_q;
      end else if (dec_rem_q != 32'd0) begin
        state_d  = DECEL;
        take_dec = 1'b1;
        go_p     = pmin({1'b0, t0_q}, sat_add(dec_p_q, {1'b0, delta_q}));
      end else begin
        state_d = DONE;
        go      = 1'b0;
      end
      go_p = pmax(go_p, 33'(MIN_PERIOD));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      t0_q        <= '0;
      tna_q       <= '0;
      delta_q     <= '0;
      setup_cnt_q <= '0;
      acc_rem_q   <= '0;
      cru_rem_q   <= '0;
      dec_rem_q   <= '0;
      acc_p_q     <= '0;
      dec_p_q     <= '0;
      cruise_p_q  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= state_d inside {LOAD, SETUP, ACCEL, CRUISE, DECEL};
      finish_q <= (state_d == DONE);
      if (state_q == LOAD) begin
        dir_q       <= dir_in_i;
        t0_q        <= params_i[PARAM_T0];
        tna_q       <= params_i[PARAM_TNA];
        delta_q     <= params_i[PARAM_DELTA];
        acc_rem_q   <= ld_ramp;
        cru_rem_q   <= ld_n - (ld_ramp << 1);
        dec_rem_q   <= ld_ramp;
        acc_p_q     <= {1'b0, params_i[PARAM_T0]};
        cruise_p_q  <= ld_cp;
        dec_p_q     <= ld_cp;
        setup_cnt_q <= '0;
      end
      if (state_q == SETUP) setup_cnt_q <= setup_cnt_q + 32'd1;
      if (take_acc) begin
        acc_rem_q <= acc_rem_q - 32'd1;
        acc_p_q   <= sat_sub(acc_p_q, {1'b0, delta_q});
      end
      if (take_cru) cru_rem_q <= cru_rem_q - 32'd1;
      if (take_dec) begin
        dec_rem_q <= dec_rem_q - 32'd1;
        dec_p_q   <= sat_add(dec_p_q, {1'b0, delta_q});
      end
    end
  end

  step_pulse_timer #(.STEP_PULSE(STEP_PULSE)) u_tmr (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .kill_i        (kill),
    .go_i          (go),
    .period_i      (go_p),
    .step_o        (tmr_step),
    .period_done_o (tmr_done)
  );

  assign step_o   = tmr_step;
  assign dir_o    = dir_q;
  assign busy_o   = busy_q;
  assign finish_o = finish_q;
endmodule
